// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: request-to-send, device-clocked bit shifting, ack sampling.
// Optional watchdog on device clock edges is enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int CW = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RTS,
    S_START,
    S_DATA,
    S_ACK,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    filter_q, filter_d;
  logic          fclk_q, fclk_d;
  logic          fall_edge;
  logic [8:0]    data_q, data_d;
  logic [3:0]    n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          c_oe_q, c_oe_d;
  logic          d_oe_q, d_oe_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          timeout;

  // Glitch filter: the filtered clock only moves after 8 identical samples.
  always_comb begin
    filter_d = {ps2c_in, filter_q[7:1]};
    fclk_d   = fclk_q;
    if (filter_d == 8'hFF)
      fclk_d = 1'b1;
    else if (filter_d == 8'h00)
      fclk_d = 1'b0;
    fall_edge = fclk_q & ~fclk_d;
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;

  always_comb begin
    wd_d    = '0;
    timeout = 1'b0;
    if (state_q inside {S_START, S_DATA, S_ACK, S_DONE} && !fall_edge) begin
      wd_d    = wd_q + 1'b1;
      timeout = (wd_d == WW'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wd_q <= '0;
    else
      wd_q <= wd_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    c_oe_d  = c_oe_q;
    d_oe_d  = d_oe_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        c_oe_d = 1'b0;
        d_oe_d = 1'b0;
        if (wr_ps2) begin
          data_d  = {~^din, din};
          err_d   = 1'b0;
          cnt_d   = '0;
          c_oe_d  = 1'b1;
          state_d = S_RTS;
        end
      end
      S_RTS: begin
        c_oe_d = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          c_oe_d  = 1'b0;
          d_oe_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (fall_edge) begin
          d_oe_d  = ~data_q[0];
          data_d  = {1'b0, data_q[8:1]};
          n_d     = 4'd8;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (fall_edge) begin
          if (n_q != 4'd0) begin
            d_oe_d = ~data_q[0];
            data_d = {1'b0, data_q[8:1]};
            n_d    = n_q - 4'd1;
          end else begin
            // Release the line so the pull-up supplies the stop bit.
            d_oe_d  = 1'b0;
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (fall_edge) begin
          err_d   = ps2d_in;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (fclk_q && ps2d_in) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout) begin
      c_oe_d  = 1'b0;
      d_oe_d  = 1'b0;
      err_d   = 1'b1;
      done_d  = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      filter_q <= '0;
      fclk_q   <= 1'b0;
      data_q   <= '0;
      n_q      <= '0;
      cnt_q    <= '0;
      c_oe_q   <= 1'b0;
      d_oe_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      filter_q <= filter_d;
      fclk_q   <= fclk_d;
      data_q   <= data_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      c_oe_q   <= c_oe_d;
      d_oe_q   <= d_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ps2c_oe      = c_oe_q;
  assign ps2d_oe      = d_oe_q;
  assign tx_done_tick = done_q;
  assign tx_err       = err_q;
  assign tx_idle      = (state_q == S_IDLE);

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: a PS/2 device model clocks frames out of the DUT and
// compares received frames, ack status and line behaviour against expectations.
module tb_ps2_tx;

  localparam int INH  = 6000;
  localparam int HALF = 30;
`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO = 200;
`else
  localparam int TO = 1000000;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err;

  // Open-drain lines with pull-ups: low if either side pulls low.
  assign ps2c_in = dev_clk & ~ps2c_oe;
  assign ps2d_in = dev_data & ~ps2d_oe;

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din),
    .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
    .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .tx_idle(tx_idle),
    .tx_done_tick(tx_done_tick), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int tick_cyc = 0;
  logic [9:0] last_rx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Filter model: a level is accepted after 8 consecutive equal samples.
  int   run_len = 8;
  logic lvl = 1'b0, filt = 1'b0, fall_pend = 1'b0;
  logic prev_d = 1'b0, prev_c = 1'b0, skip = 1'b1;

  always @(negedge clk) begin
    logic ok;
    cyc++;
    if (tx_done_tick) begin
      tick_cnt++;
      tick_cyc = cyc;
    end
    if (reset) begin
      run_len = 8; lvl = 1'b0; filt = 1'b0; fall_pend = 1'b0; skip = 1'b1;
    end else begin
      if (!skip) begin
        if (tx_idle) begin
          chk("idle_c_released", ps2c_oe, 0);
          chk("idle_d_released", ps2d_oe, 0);
        end else begin
          chk("tick_only_idle", tx_done_tick, 0);
        end
        ok = (ps2d_oe === prev_d) || fall_pend || (prev_c && !ps2c_oe) || tx_idle;
        chk("ps2d_moves_on_fall", ok, 1);
      end
      if (fall_pend) last_fall_cyc = cyc;
      if (ps2c_in == lvl) begin
        if (run_len < 8) run_len++;
      end else begin
        lvl = ps2c_in; run_len = 1;
      end
      fall_pend = 1'b0;
      if (run_len >= 8 && lvl != filt) begin
        fall_pend = filt & ~lvl;
        filt = lvl;
      end
      skip = 1'b0;
    end
    prev_d = ps2d_oe;
    prev_c = ps2c_oe;
  end

  task automatic tick_wait();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset(input int t0);
    reset = 1'b1;
    #1;
    chk("rst_c_oe", ps2c_oe, 0);
    chk("rst_d_oe", ps2d_oe, 0);
    chk("rst_idle", tx_idle, 1);
    repeat (2) tick_wait();
    reset = 1'b0;
    repeat (30) tick_wait();
    chk("rst_no_tick", tick_cnt - t0, 0);
    chk("rst_idle_after", tx_idle, 1);
  endtask

  // abort_edge: 0 = reset during rts, n = reset after edge n, -1 = none.
  // stop_edge: device stops clocking before this edge (watchdog test), -1 = none.
  task automatic do_xfer(input logic [7:0] b, input bit ack, input bit glitch,
                         input int wr_edge, input int abort_edge, input int stop_edge);
    logic [9:0] rx, exp;
    int cnt, t0;
    t0 = tick_cnt;
    wr_ps2 = 1'b1; din = b;
    tick_wait();
    wr_ps2 = 1'b0; din = 8'($urandom);
    chk("latency_c_oe", ps2c_oe, 1);
    chk("err_cleared", tx_err, 0);
    if (abort_edge == 0) begin
      repeat (100) tick_wait();
      chk("rts_c_oe", ps2c_oe, 1);
      pulse_reset(t0);
      return;
    end
    cnt = 0;
    while (ps2c_oe && cnt < 20000) begin
      cnt++;
      tick_wait();
    end
    chk("inhibit_len", cnt, INH);
    chk("start_bit", ps2d_oe, 1);
    rx = '0;
    for (int e = 1; e <= 11; e++) begin
      repeat (HALF) tick_wait();
      if (glitch) begin
        dev_clk = 1'b0;
        repeat (3) tick_wait();
        dev_clk = 1'b1;
        repeat (12) tick_wait();
      end
      if (e == stop_edge) begin
        cnt = 0;
        while (tick_cnt == t0 && cnt < 3 * TO) begin
          cnt++;
          tick_wait();
        end
        chk("wd_tick", tick_cnt - t0, 1);
        chk("wd_delay", tick_cyc - last_fall_cyc, TO);
        chk("wd_err", tx_err, 1);
        chk("wd_c_oe", ps2c_oe, 0);
        chk("wd_d_oe", ps2d_oe, 0);
        return;
      end
      dev_clk = 1'b0;
      repeat (HALF) tick_wait();
      if (e <= 10) rx[e-1] = ps2d_in;
      if (e == wr_edge) begin
        wr_ps2 = 1'b1; din = 8'hFF;
        tick_wait();
        wr_ps2 = 1'b0;
        chk("busy_during_data", tx_idle, 0);
      end
      if (e == abort_edge) begin
        dev_clk = 1'b1;
        pulse_reset(t0);
        return;
      end
      if (e == 10) dev_data = ack ? 1'b0 : 1'b1;
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
    cnt = 0;
    while (tick_cnt == t0 && cnt < 300) begin
      cnt++;
      tick_wait();
    end
    repeat (20) tick_wait();
    exp = {1'b1, ~^b, b};
    chk("tick_count", tick_cnt - t0, 1);
    chk("tx_err", tx_err, !ack);
    chk("rx_frame", rx, exp);
    chk("rx_byte", rx[7:0], b);
    chk("idle_after", tx_idle, 1);
    $display("xfer din=0x%02h ack=%0d glitch=%0d rx=0x%03h err=%0d", b, ack, glitch, rx, tx_err);
    last_rx = rx;
  endtask

  initial begin
    logic [7:0] rb;
    #2;
    chk("reset_c_oe", ps2c_oe, 0);
    chk("reset_d_oe", ps2d_oe, 0);
    chk("reset_idle", tx_idle, 1);
    chk("reset_tick", tx_done_tick, 0);
    chk("reset_err", tx_err, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) tick_wait();

    do_xfer(8'hF4, 1'b1, 1'b0, -1, -1, -1);
    chk("pin_f4_frame", last_rx, 10'h2F4);
    do_xfer(8'h55, 1'b1, 1'b0, -1, -1, -1);
    chk("pin_55_frame", last_rx, 10'h355);
    chk("pin_55_parity", last_rx[8], 1);
    do_xfer(8'($urandom), 1'b0, 1'b0, -1, -1, -1);
    chk("pin_noack_err", tx_err, 1);
    do_xfer(8'h3C, 1'b1, 1'b0, 3, -1, -1);
    chk("pin_3c_frame", last_rx, 10'h33C);
    do_xfer(8'hA7, 1'b1, 1'b0, -1, 0, -1);
    $display("xfer reset during rts done");
    do_xfer(8'hA7, 1'b1, 1'b0, -1, 5, -1);
    $display("xfer reset after edge 5 done");
    rb = 8'($urandom);
    do_xfer(rb, 1'b1, 1'b1, -1, -1, -1);
    rb = 8'($urandom);
    do_xfer(rb, 1'($urandom), 1'b0, -1, -1, -1);
`ifdef PS2_TX_TIMEOUT_EN
    do_xfer(8'hF4, 1'b1, 1'b0, -1, -1, 5);
    $display("xfer watchdog after edge 4 done");
`endif
    repeat (10) tick_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
